// File: rtl/dmux_1to2_stream.sv
// Buffered 1-to-2 stream demux: each accepted word is steered by sel_in into
// one of two independent circular-buffer FIFOs that drain through their own handshakes.
module dmux_1to2_stream #(
   parameter  int DATA_W = 8,
   parameter  int DEPTH  = 4,
   localparam int CNT_W  = $clog2(DEPTH) + 1
) (
   input  logic              clk_in,
   input  logic              rst_n_in,
   input  logic [DATA_W-1:0] d_in,
   input  logic              sel_in,
   input  logic              valid_in,
   output logic              ready_out,
   output logic [DATA_W-1:0] y0_out,
   output logic              y0_valid_out,
   input  logic              y0_ready_in,
   output logic [DATA_W-1:0] y1_out,
   output logic              y1_valid_out,
   input  logic              y1_ready_in,
   output logic [CNT_W-1:0]  cnt0_out,
   output logic [CNT_W-1:0]  cnt1_out
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [DATA_W-1:0] mem_q [2][DEPTH];
   logic [DATA_W-1:0] mem_d [2][DEPTH];
   logic [PTR_W-1:0]  wr_q [2];
   logic [PTR_W-1:0]  wr_d [2];
   logic [PTR_W-1:0]  rd_q [2];
   logic [PTR_W-1:0]  rd_d [2];
   logic [CNT_W-1:0]  cnt_q [2];
   logic [CNT_W-1:0]  cnt_d [2];
   logic [1:0]        push;
   logic [1:0]        pop;
   logic [1:0]        not_empty;

   // Full FIFO stays closed even when it pops this cycle: ready never depends on y*_ready_in.
   assign ready_out = sel_in ? (cnt_q[1] != FULL_CNT) : (cnt_q[0] != FULL_CNT);

   assign not_empty[0] = (cnt_q[0] != '0);
   assign not_empty[1] = (cnt_q[1] != '0);

   assign push[0] = valid_in & ready_out & ~sel_in;
   assign push[1] = valid_in & ready_out &  sel_in;
   assign pop[0]  = not_empty[0] & y0_ready_in;
   assign pop[1]  = not_empty[1] & y1_ready_in;

   always_comb begin
      mem_d = mem_q;
      wr_d  = wr_q;
      rd_d  = rd_q;
      cnt_d = cnt_q;
      for (int k = 0; k < 2; k++) begin
         if (push[k]) begin
            mem_d[k][wr_q[k]] = d_in;
            wr_d[k]           = wr_q[k] + PTR_W'(1);
         end
         if (pop[k]) begin
            rd_d[k] = rd_q[k] + PTR_W'(1);
         end
         case ({push[k], pop[k]})
            2'b10:   cnt_d[k] = cnt_q[k] + CNT_W'(1);
            2'b01:   cnt_d[k] = cnt_q[k] - CNT_W'(1);
            default: cnt_d[k] = cnt_q[k];
         endcase
      end
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < DEPTH; i++) begin
               mem_q[k][i] <= '0;
            end
            wr_q[k]  <= '0;
            rd_q[k]  <= '0;
            cnt_q[k] <= '0;
         end
      end else begin
         mem_q <= mem_d;
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

   // Heads read straight from registered state; empty outputs are forced to zero.
   assign y0_out       = not_empty[0] ? mem_q[0][rd_q[0]] : '0;
   assign y1_out       = not_empty[1] ? mem_q[1][rd_q[1]] : '0;
   assign y0_valid_out = not_empty[0];
   assign y1_valid_out = not_empty[1];
   assign cnt0_out     = cnt_q[0];
   assign cnt1_out     = cnt_q[1];

endmodule

// File: tb/tb_dmux_1to2_stream.sv
// Randomized and directed bench for dmux_1to2_stream against a queue-based
// reference model of the two output streams.
module tb_dmux_1to2_stream;

   localparam int DATA_W = 8;
   localparam int DEPTH  = 4;
   localparam int CNT_W  = $clog2(DEPTH) + 1;

   logic              clk_in = 1'b0;
   logic              rst_n_in;
   logic [DATA_W-1:0] d_in;
   logic              sel_in;
   logic              valid_in;
   logic              ready_out;
   logic [DATA_W-1:0] y0_out;
   logic              y0_valid_out;
   logic              y0_ready_in;
   logic [DATA_W-1:0] y1_out;
   logic              y1_valid_out;
   logic              y1_ready_in;
   logic [CNT_W-1:0]  cnt0_out;
   logic [CNT_W-1:0]  cnt1_out;

   int vec = 0;
   int err = 0;

   logic [DATA_W-1:0] q0[$];
   logic [DATA_W-1:0] q1[$];
   bit                last_acc;

   always #5 clk_in = ~clk_in;

   dmux_1to2_stream #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
      .clk_in(clk_in), .rst_n_in(rst_n_in), .d_in(d_in), .sel_in(sel_in),
      .valid_in(valid_in), .ready_out(ready_out),
      .y0_out(y0_out), .y0_valid_out(y0_valid_out), .y0_ready_in(y0_ready_in),
      .y1_out(y1_out), .y1_valid_out(y1_valid_out), .y1_ready_in(y1_ready_in),
      .cnt0_out(cnt0_out), .cnt1_out(cnt1_out)
   );

   // Advance one clock; the model applies the stream rules to the inputs seen before the edge.
   task automatic tick();
      bit acc, p0, p1, s;
      logic [DATA_W-1:0] d;
      acc = valid_in && (sel_in ? (q1.size() < DEPTH) : (q0.size() < DEPTH));
      p0  = y0_ready_in && (q0.size() > 0);
      p1  = y1_ready_in && (q1.size() > 0);
      s   = sel_in;
      d   = d_in;
      @(posedge clk_in);
      #1;
      if (p0) void'(q0.pop_front());
      if (p1) void'(q1.pop_front());
      if (acc) begin
         if (s) q1.push_back(d);
         else   q0.push_back(d);
      end
      last_acc = acc;
   endtask

   task automatic test_reset();
      rst_n_in = 1'b0; valid_in = 1'b0; sel_in = 1'b0; d_in = '0;
      y0_ready_in = 1'b0; y1_ready_in = 1'b0;
      repeat (3) @(posedge clk_in);
      #1;
      vec++; if (y0_valid_out !== 1'b0 || y1_valid_out !== 1'b0) begin err++; $display("FAIL reset_valid: got %b%b exp 00", y0_valid_out, y1_valid_out); end
      vec++; if (cnt0_out !== '0 || cnt1_out !== '0) begin err++; $display("FAIL reset_cnt: got %0d/%0d exp 0/0", cnt0_out, cnt1_out); end
      rst_n_in = 1'b1;
      tick();
      vec++; if (y0_out !== '0 || y1_out !== '0) begin err++; $display("FAIL reset_data: got %h/%h exp 00/00", y0_out, y1_out); end
      vec++; if (ready_out !== 1'b1) begin err++; $display("FAIL reset_ready_sel0: got %b exp 1", ready_out); end
      sel_in = 1'b1; #1;
      vec++; if (ready_out !== 1'b1) begin err++; $display("FAIL reset_ready_sel1: got %b exp 1", ready_out); end
      vec++; if (cnt0_out !== '0 || cnt1_out !== '0 || y0_valid_out !== 1'b0) begin err++; $display("FAIL post_reset_state: got %0d/%0d v0=%b exp 0/0 v0=0", cnt0_out, cnt1_out, y0_valid_out); end
      sel_in = 1'b0;
   endtask

   task automatic test_route1();
      d_in = 8'hA5; sel_in = 1'b1; valid_in = 1'b1; y1_ready_in = 1'b0;
      tick();
      valid_in = 1'b0;
      vec++; if (y1_valid_out !== 1'b1 || y1_out !== 8'hA5) begin err++; $display("FAIL route1_data: got v=%b %h exp v=1 a5", y1_valid_out, y1_out); end
      vec++; if (cnt1_out !== CNT_W'(1) || y0_valid_out !== 1'b0) begin err++; $display("FAIL route1_cnt: got cnt1=%0d v0=%b exp 1 0", cnt1_out, y0_valid_out); end
      y1_ready_in = 1'b1;
      tick();
      y1_ready_in = 1'b0;
      vec++; if (cnt1_out !== '0 || y1_valid_out !== 1'b0) begin err++; $display("FAIL route1_pop: got cnt1=%0d v=%b exp 0 0", cnt1_out, y1_valid_out); end
   endtask

   task automatic test_fill_stall();
      int n;
      int cyc;
      y0_ready_in = 1'b0; sel_in = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         d_in = DATA_W'(i); valid_in = 1'b1; #1;
         vec++; if (ready_out !== 1'b1) begin err++; $display("FAIL fill_ready_%0d: got %b exp 1", i, ready_out); end
         tick();
      end
      d_in = 8'h05;
      tick();
      vec++; if (ready_out !== 1'b0 || cnt0_out !== CNT_W'(4)) begin err++; $display("FAIL stall_full: got rdy=%b cnt0=%0d exp 0 4", ready_out, cnt0_out); end
      sel_in = 1'b1; #1;
      vec++; if (ready_out !== 1'b1) begin err++; $display("FAIL stall_switch_sel: got %b exp 1", ready_out); end
      sel_in = 1'b0; #1;
      y0_ready_in = 1'b1; #1;
      vec++; if (ready_out !== 1'b0) begin err++; $display("FAIL full_with_pop: got %b exp 0", ready_out); end
      n = 0;
      cyc = 0;
      while (n < 5 && cyc < 20) begin
         if (y0_valid_out) begin
            vec++; if (y0_out !== DATA_W'(n + 1)) begin err++; $display("FAIL drain_order_%0d: got %h exp %h", n, y0_out, n + 1); end
            n++;
         end
         tick();
         if (last_acc) valid_in = 1'b0;
         cyc++;
      end
      vec++; if (n != 5 || valid_in !== 1'b0) begin err++; $display("FAIL drain_count: got %0d words acc=%b exp 5 1", n, ~valid_in); end
      y0_ready_in = 1'b0;
   endtask

   task automatic test_simul();
      logic [DATA_W-1:0] w [3];
      for (int i = 0; i < 3; i++) w[i] = DATA_W'($urandom);
      y0_ready_in = 1'b0; sel_in = 1'b0; valid_in = 1'b1;
      d_in = w[0]; tick();
      d_in = w[1]; tick();
      d_in = w[2]; y0_ready_in = 1'b1; tick();
      valid_in = 1'b0;
      vec++; if (cnt0_out !== CNT_W'(2)) begin err++; $display("FAIL simul_cnt: got %0d exp 2", cnt0_out); end
      for (int i = 1; i < 3; i++) begin
         vec++; if (y0_out !== w[i]) begin err++; $display("FAIL simul_order_%0d: got %h exp %h", i, y0_out, w[i]); end
         tick();
      end
      y0_ready_in = 1'b0;
      vec++; if (cnt0_out !== '0) begin err++; $display("FAIL simul_empty: got %0d exp 0", cnt0_out); end
   endtask

   task automatic test_interleave();
      logic [DATA_W-1:0] got0[$];
      logic [DATA_W-1:0] got1[$];
      int i;
      int cyc;
      bit ok;
      i = 0; cyc = 0;
      y0_ready_in = 1'b1; y1_ready_in = 1'b0;
      while ((i < 16 || y0_valid_out || y1_valid_out) && cyc < 100) begin
         valid_in = (i < 16);
         d_in     = DATA_W'(8'h10 + i);
         sel_in   = i[0];
         #1;
         if (y0_valid_out && y0_ready_in) got0.push_back(y0_out);
         if (y1_valid_out && y1_ready_in) got1.push_back(y1_out);
         tick();
         if (last_acc) i++;
         y1_ready_in = ~y1_ready_in;
         cyc++;
      end
      valid_in = 1'b0; y0_ready_in = 1'b0; y1_ready_in = 1'b0;
      ok = (got0.size() == 8) && (got1.size() == 8);
      if (ok) for (int j = 0; j < 8; j++)
         if (got0[j] !== DATA_W'(8'h10 + 2*j) || got1[j] !== DATA_W'(8'h11 + 2*j)) ok = 0;
      vec++; if (!ok) begin err++; $display("FAIL interleave: got %0d/%0d words exp 8/8 evens/odds in order", got0.size(), got1.size()); end
   endtask

   task automatic test_reset_mid();
      y0_ready_in = 1'b0; y1_ready_in = 1'b0; valid_in = 1'b1;
      for (int i = 0; i < 5; i++) begin
         sel_in = (i >= 3); d_in = DATA_W'($urandom); tick();
      end
      valid_in = 1'b0;
      vec++; if (cnt0_out !== CNT_W'(3) || cnt1_out !== CNT_W'(2)) begin err++; $display("FAIL mid_pre: got %0d/%0d exp 3/2", cnt0_out, cnt1_out); end
      #1 rst_n_in = 1'b0;
      #1;
      q0.delete(); q1.delete();
      vec++; if (cnt0_out !== '0 || cnt1_out !== '0 || y0_valid_out !== 1'b0 || y1_valid_out !== 1'b0) begin err++; $display("FAIL mid_async: got %0d/%0d v=%b%b exp 0/0 v=00", cnt0_out, cnt1_out, y0_valid_out, y1_valid_out); end
      #1 rst_n_in = 1'b1;
      d_in = 8'h77; sel_in = 1'b0; valid_in = 1'b1;
      tick();
      valid_in = 1'b0;
      vec++; if (y0_valid_out !== 1'b1 || y0_out !== 8'h77 || cnt0_out !== CNT_W'(1) || cnt1_out !== '0 || y1_valid_out !== 1'b0) begin err++; $display("FAIL mid_next: got v0=%b %h c=%0d/%0d v1=%b exp 1 77 1/0 0", y0_valid_out, y0_out, cnt0_out, cnt1_out, y1_valid_out); end
      y0_ready_in = 1'b1; tick(); y0_ready_in = 1'b0;
   endtask

   task automatic test_random();
      logic [DATA_W-1:0] e0, e1;
      bit                er;
      for (int c = 0; c < 400; c++) begin
         if (!(valid_in && !last_acc)) begin
            valid_in = ($urandom_range(0, 3) != 0);
            d_in     = DATA_W'($urandom);
         end
         sel_in      = $urandom_range(0, 1);
         y0_ready_in = ($urandom_range(0, 2) != 0);
         y1_ready_in = ($urandom_range(0, 3) == 0);
         #1;
         e0 = (q0.size() > 0) ? q0[0] : '0;
         e1 = (q1.size() > 0) ? q1[0] : '0;
         er = sel_in ? (q1.size() < DEPTH) : (q0.size() < DEPTH);
         vec++;
         if (y0_out !== e0 || y1_out !== e1 || y0_valid_out !== (q0.size() > 0) || y1_valid_out !== (q1.size() > 0) ||
             cnt0_out !== CNT_W'(q0.size()) || cnt1_out !== CNT_W'(q1.size()) || ready_out !== er) begin
            err++;
            $display("FAIL random_%0d: got y=%h/%h c=%0d/%0d rdy=%b exp y=%h/%h c=%0d/%0d rdy=%b",
                     c, y0_out, y1_out, cnt0_out, cnt1_out, ready_out, e0, e1, q0.size(), q1.size(), er);
         end
         tick();
      end
      valid_in = 1'b0;
   endtask

   initial begin
      last_acc = 1'b0;
      test_reset();
      test_route1();
      test_fill_stall();
      test_simul();
      test_interleave();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vec, err);
      $finish;
   end

endmodule

// File: doc/dmux_1to2_stream.md
# dmux_1to2_stream

Buffered 1-to-2 stream demultiplexer. It accepts one data word per handshake and steers it, by a per-word select, into one of two independent output FIFOs. Each output drains through its own valid/ready handshake. It sits directly downstream of the data source and replaces the bare combinational 1-to-2 demux where the two consumers can stall independently.

## Interface
Parameters:
- DATA_W, 8: width of data word.
- DEPTH, 4: entries per output FIFO; power of 2, at least 2.
- CNT_W, $clog2(DEPTH)+1: occupancy counter width (derived, not overridden).

Ports:
- clk_in, input, 1: single clock; all state updates on the rising edge.
- rst_n_in, input, 1: asynchronous, active-low reset; deassertion is synchronous to clk_in externally.
- d_in, input, DATA_W: input data word.
- sel_in, input, 1: destination of d_in; 0 routes to output 0, 1 routes to output 1.
- valid_in, input, 1: d_in/sel_in valid.
- ready_out, output, 1: block can accept the word currently addressed by sel_in.
- y0_out, output, DATA_W: head word of FIFO 0.
- y0_valid_out, output, 1: FIFO 0 not empty.
- y0_ready_in, input, 1: consumer 0 takes y0_out.
- y1_out, output, DATA_W: head word of FIFO 1.
- y1_valid_out, output, 1: FIFO 1 not empty.
- y1_ready_in, input, 1: consumer 1 takes y1_out.
- cnt0_out, output, CNT_W: FIFO 0 occupancy, 0..DEPTH.
- cnt1_out, output, CNT_W: FIFO 1 occupancy, 0..DEPTH.

## Operation
- Each FIFO is a circular buffer with write pointer, read pointer (log2(DEPTH) bits, natural wrap) and occupancy count.
- ready_out = sel_in ? (cnt1 != DEPTH) : (cnt0 != DEPTH). This is combinational from sel_in and registered counts only, never from y*_ready_in.
- Accept: valid_in && ready_out. The accepted word is written to mem[wr_ptr] of the selected FIFO, and that FIFO's wr_ptr increments. The other FIFO is untouched.
- Pop k: yk_valid_out && yk_ready_in. rd_ptr increments.
- Count update per FIFO: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
- Full FIFO: ready_out is low for that select even if a pop occurs in the same cycle (no full-pass-through). The word stays held by the source.
- Empty FIFO: no bypass. yk_valid_out = (cntk != 0). yk_out = mem[rd_ptr] when valid and 0 when empty.
- The source must hold d_in and sel_in stable while valid_in && !ready_out. Changing sel_in while stalled is legal: ready_out re-evaluates against the new destination, and no word is lost or duplicated.
- Consumers may hold yk_ready_in high continuously. One output stalling never blocks words destined for the other output.
- Ordering: words to the same output leave in acceptance order.

## Timing
- Reset (async assert): pointers, counts and memories clear to 0. Outputs during and after reset: y0_out=y1_out=0, y0_valid_out=y1_valid_out=0, cnt0_out=cnt1_out=0. ready_out=1 for either select.
- Reset asserted mid-operation discards all buffered words immediately, without waiting for a clock edge.
- Latency: a word accepted at edge N is visible on yk_out with yk_valid_out=1 after edge N (one cycle).
- Throughput: one accept per cycle and one pop per output per cycle, sustained.
- Back-to-back words to the same output with its consumer always ready keep cntk at 1 with no bubbles.

## Test plan
- Reset check: hold rst_n_in=0, then release with valid_in=0. Required: all valid outputs 0, counts 0, data 0, ready_out=1.
- Route to output 1: send 0xA5 with sel_in=1 and y1_ready_in=0. Required: after one edge y1_valid_out=1, y1_out=0xA5, cnt1_out=1, y0_valid_out=0. Then raise y1_ready_in for one cycle. Required: cnt1_out=0.
- Fill and stall: with DEPTH=4 and y0_ready_in=0, send 0x01..0x05 with sel_in=0. Required: ready_out=0 with cnt0_out=4 while 0x05 is held. Switching sel_in=1 gives ready_out=1. Raising y0_ready_in pops 0x01..0x04 in order, then 0x05 is accepted.
- Simultaneous push and pop: FIFO 0 holds 2 words, one cycle with accept to output 0 and a pop of output 0. Required: cnt0_out stays 2 and order is preserved. Separately, FIFO full plus pop: ready_out stays 0 that cycle.
- Interleaved independence: alternate sel_in 0/1 for 16 words (0x10..0x1F) with y0_ready_in=1 and y1_ready_in toggling every cycle. Required: output 0 gets the even-indexed words in order, output 1 the odd-indexed words in order, none lost, pointers wrap correctly.
- Reset mid-stream: with cnt0_out=3 and cnt1_out=2, pulse rst_n_in low between clock edges. Required: valid outputs and counts drop to 0 immediately. The next accepted word appears alone at the output after one edge.
